// File: rtl/wb_regfile.sv
// -----------------------------------------------------------------------------
// wb_regfile
// Writeback stage plus architectural register file.
//
// Takes the MEM/WB pipeline outputs, extracts and extends load data, selects
// the writeback value, writes the register file and serves the two ID-stage
// read ports with same-cycle write bypass. It also keeps a sticky
// misaligned-load flag and a retired-instruction counter.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   wb_valid            instruction present in WB this cycle
//   reg_write           instruction writes rd
//   mem_to_reg          1 = load data, 0 = ALU result
//   ld_funct3           load type (LB/LH/LW/LBU/LHU, others act as LW)
//   addr_lo             data address bits [1:0]
//   do_mem, y_alu       raw memory word, ALU result
//   rd, rs1, rs2        destination and ID read addresses
//   rs1_data, rs2_data  read data with write bypass (combinational)
//   wb_data, wb_we      writeback value / effective write enable (comb.)
//   wb_rd               rd passthrough for the hazard unit
//   misalign_err        sticky: a misaligned load was suppressed
//   instret             retired, non-faulting instruction count
// -----------------------------------------------------------------------------
module wb_regfile #(
    parameter int NREG  = 32,
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wb_valid,
    input  logic                     reg_write,
    input  logic                     mem_to_reg,
    input  logic [2:0]               ld_funct3,
    input  logic [1:0]               addr_lo,
    input  logic [XLEN-1:0]          do_mem,
    input  logic [XLEN-1:0]          y_alu,
    input  logic [$clog2(NREG)-1:0]  rd,
    input  logic [$clog2(NREG)-1:0]  rs1,
    input  logic [$clog2(NREG)-1:0]  rs2,
    output logic [XLEN-1:0]          rs1_data,
    output logic [XLEN-1:0]          rs2_data,
    output logic [XLEN-1:0]          wb_data,
    output logic                     wb_we,
    output logic [$clog2(NREG)-1:0]  wb_rd,
    output logic                     misalign_err,
    output logic [CNT_W-1:0]         instret
);

    localparam int RW = $clog2(NREG);

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Little-endian byte/halfword extraction with sign or zero extension.
    // Unknown funct3 codes fall through to a full-word load.
    function automatic logic [XLEN-1:0] load_extract(
        input logic [2:0]      f3,
        input logic [1:0]      a,
        input logic [XLEN-1:0] w
    );
        logic [XLEN-1:0] byte_sh;
        logic [XLEN-1:0] half_sh;
        logic [7:0]      b;
        logic [15:0]     h;
        logic [XLEN-1:0] r;
        byte_sh = w >> {a, 3'b000};
        half_sh = w >> {a[1], 4'b0000};
        b       = byte_sh[7:0];
        h       = half_sh[15:0];
        case (f3)
            F3_LB:   r = {{(XLEN-8){b[7]}}, b};
            F3_LBU:  r = {{(XLEN-8){1'b0}}, b};
            F3_LH:   r = {{(XLEN-16){h[15]}}, h};
            F3_LHU:  r = {{(XLEN-16){1'b0}}, h};
            F3_LW:   r = w;
            default: r = w;
        endcase
        return r;
    endfunction

    logic [XLEN-1:0]  regs_r [NREG];
    logic             misalign_err_r;
    logic [CNT_W-1:0] instret_r;

    logic             is_byte_s;
    logic             is_half_s;
    logic             is_word_s;
    logic             misaligned_s;
    logic             retire_s;
    logic [XLEN-1:0]  wb_data_s;
    logic             wb_we_s;
    logic [XLEN-1:0]  rs1_data_s;
    logic [XLEN-1:0]  rs2_data_s;

    // Decode load size, detect misalignment and form the writeback value/enable.
    always_comb begin
        is_byte_s    = 1'b0;
        is_half_s    = 1'b0;
        is_word_s    = 1'b0;
        case (ld_funct3)
            F3_LB, F3_LBU: is_byte_s = 1'b1;
            F3_LH, F3_LHU: is_half_s = 1'b1;
            default:       is_word_s = 1'b1;
        endcase
        misaligned_s = wb_valid & mem_to_reg &
                       ((is_half_s & addr_lo[0]) | (is_word_s & (addr_lo != 2'b00)));
        if (mem_to_reg) begin
            wb_data_s = load_extract(ld_funct3, addr_lo, do_mem);
        end else begin
            wb_data_s = y_alu;
        end
        wb_we_s  = wb_valid & reg_write & (rd != {RW{1'b0}}) & ~misaligned_s;
        retire_s = wb_valid & ~misaligned_s;
    end

    // Read ports: x0 reads zero, a same-cycle write to the address is bypassed.
    always_comb begin
        if (rs1 == {RW{1'b0}}) begin
            rs1_data_s = {XLEN{1'b0}};
        end else if (wb_we_s && (rs1 == rd)) begin
            rs1_data_s = wb_data_s;
        end else begin
            rs1_data_s = regs_r[rs1];
        end
        if (rs2 == {RW{1'b0}}) begin
            rs2_data_s = {XLEN{1'b0}};
        end else if (wb_we_s && (rs2 == rd)) begin
            rs2_data_s = wb_data_s;
        end else begin
            rs2_data_s = regs_r[rs2];
        end
    end

    // Register file write; x0 is excluded by wb_we_s so it stays zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= {XLEN{1'b0}};
            end
        end else if (wb_we_s) begin
            regs_r[rd] <= wb_data_s;
        end
    end

    // Sticky misaligned-load flag and wrapping retired-instruction counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            misalign_err_r <= 1'b0;
            instret_r      <= {CNT_W{1'b0}};
        end else begin
            if (misaligned_s) begin
                misalign_err_r <= 1'b1;
            end
            if (retire_s) begin
                instret_r <= instret_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign rs1_data     = rs1_data_s;
    assign rs2_data     = rs2_data_s;
    assign wb_data      = wb_data_s;
    assign wb_we        = wb_we_s;
    assign wb_rd        = rd;
    assign misalign_err = misalign_err_r;
    assign instret      = instret_r;

endmodule

// File: tb/tb_wb_regfile.sv
// -----------------------------------------------------------------------------
// tb_wb_regfile
// Self-checking bench for wb_regfile. A behavioural model (register array,
// retire count, sticky error bit) derived from the writeback rules predicts
// every output. A second instance with a 4-bit counter exercises wrap-around.
// -----------------------------------------------------------------------------
module tb_wb_regfile;

    logic        clk;
    logic        reset;
    logic        wb_valid;
    logic        reg_write;
    logic        mem_to_reg;
    logic [2:0]  ld_funct3;
    logic [1:0]  addr_lo;
    logic [31:0] do_mem;
    logic [31:0] y_alu;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] wb_data;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic        misalign_err;
    logic [31:0] instret;

    logic [31:0] rs1_data_w;
    logic [31:0] rs2_data_w;
    logic [31:0] wb_data_w;
    logic        wb_we_w;
    logic [4:0]  wb_rd_w;
    logic        misalign_err_w;
    logic [3:0]  instret_w;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [31:0] m_regs [32];
    int unsigned m_cnt;
    bit          m_err;

    wb_regfile #(.NREG(32), .XLEN(32), .CNT_W(32)) u_dut (
        .clk(clk), .reset(reset), .wb_valid(wb_valid), .reg_write(reg_write),
        .mem_to_reg(mem_to_reg), .ld_funct3(ld_funct3), .addr_lo(addr_lo),
        .do_mem(do_mem), .y_alu(y_alu), .rd(rd), .rs1(rs1), .rs2(rs2),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .wb_data(wb_data),
        .wb_we(wb_we), .wb_rd(wb_rd), .misalign_err(misalign_err),
        .instret(instret)
    );

    wb_regfile #(.NREG(32), .XLEN(32), .CNT_W(4)) u_dut_w (
        .clk(clk), .reset(reset), .wb_valid(wb_valid), .reg_write(reg_write),
        .mem_to_reg(mem_to_reg), .ld_funct3(ld_funct3), .addr_lo(addr_lo),
        .do_mem(do_mem), .y_alu(y_alu), .rd(rd), .rs1(rs1), .rs2(rs2),
        .rs1_data(rs1_data_w), .rs2_data(rs2_data_w), .wb_data(wb_data_w),
        .wb_we(wb_we_w), .wb_rd(wb_rd_w), .misalign_err(misalign_err_w),
        .instret(instret_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] a,
                                             input logic [31:0] dm);
        int unsigned b;
        int unsigned h;
        b = (dm >> (8 * int'(a))) & 32'hFF;
        h = (dm >> (16 * (int'(a) / 2))) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'd4:    return b;
            3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'd5:    return h;
            default: return dm;
        endcase
    endfunction

    function automatic bit ref_misaligned();
        bit half_op;
        bit word_op;
        half_op = (ld_funct3 == 3'd1) || (ld_funct3 == 3'd5);
        word_op = !(half_op || ld_funct3 == 3'd0 || ld_funct3 == 3'd4);
        return wb_valid && mem_to_reg &&
               ((half_op && addr_lo % 2 != 0) || (word_op && addr_lo != 0));
    endfunction

    function automatic logic [31:0] ref_read(input logic [4:0] s, input bit we,
                                             input logic [31:0] wv);
        if (s == 0) return 32'h0;
        if (we && s == rd) return wv;
        return m_regs[s];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        m_cnt = 0;
        m_err = 1'b0;
    endtask

    task automatic drive(input logic v, input logic rw, input logic m2r,
                         input logic [2:0] f3, input logic [1:0] a,
                         input logic [31:0] dm, input logic [31:0] y,
                         input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2);
        wb_valid = v; reg_write = rw; mem_to_reg = m2r; ld_funct3 = f3;
        addr_lo = a; do_mem = dm; y_alu = y; rd = d; rs1 = s1; rs2 = s2;
    endtask

    // Called at posedge+1 with inputs driven: check combinational outputs,
    // cross the edge, update the model and check the state outputs.
    task automatic run_cycle();
        bit          mis;
        bit          we;
        logic [31:0] wv;
        #2;
        mis = ref_misaligned();
        wv  = mem_to_reg ? ref_load(ld_funct3, addr_lo, do_mem) : y_alu;
        we  = wb_valid && reg_write && rd != 0 && !mis;
        check_val("wb_data", wb_data, wv);
        check_val("wb_we", {31'b0, wb_we}, {31'b0, we});
        check_val("wb_rd", {27'b0, wb_rd}, {27'b0, rd});
        check_val("rs1_data", rs1_data, ref_read(rs1, we, wv));
        check_val("rs2_data", rs2_data, ref_read(rs2, we, wv));
        @(posedge clk);
        if (we) m_regs[rd] = wv;
        if (mis) m_err = 1'b1;
        if (wb_valid && !mis) m_cnt++;
        #1;
        check_val("instret", instret, m_cnt);
        check_val("instret_w", {28'b0, instret_w}, m_cnt % 16);
        check_val("misalign_err", {31'b0, misalign_err}, {31'b0, m_err});
    endtask

    logic [31:0] ld_exp [5];
    logic [2:0]  ld_f3  [5];
    logic [1:0]  ld_a   [5];

    initial begin
        reset = 1'b1;
        model_reset();
        drive(1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_val("rst_instret", instret, 32'h0);
        check_val("rst_err", {31'b0, misalign_err}, 32'h0);

        // Counter wrap on the 4-bit instance: 16 retirements return it to 0
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 32'h0, 32'(i), 5'd9, 5'd0, 5'd0);
            run_cycle();
        end
        check_val("wrap_zero", {28'b0, instret_w}, 32'h0);

        // ALU writeback with same-cycle bypass, then read back after the edge
        drive(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 32'h0, 32'h1234_5678, 5'd7, 5'd7, 5'd7);
        #2;
        check_val("bypass_rs1", rs1_data, 32'h1234_5678);
        #(-0);
        run_cycle();
        drive(1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 32'h0, 32'h0, 5'd0, 5'd7, 5'd0);
        #2;
        check_val("x7_after", rs1_data, 32'h1234_5678);
        @(posedge clk);
        #1;

        // Load extension against fixed expected values
        ld_f3[0] = 3'd0; ld_a[0] = 2'd3; ld_exp[0] = 32'hFFFF_FF80;
        ld_f3[1] = 3'd4; ld_a[1] = 2'd3; ld_exp[1] = 32'h0000_0080;
        ld_f3[2] = 3'd1; ld_a[2] = 2'd2; ld_exp[2] = 32'hFFFF_80FF;
        ld_f3[3] = 3'd5; ld_a[3] = 2'd0; ld_exp[3] = 32'h0000_7F01;
        ld_f3[4] = 3'd2; ld_a[4] = 2'd0; ld_exp[4] = 32'h80FF_7F01;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 1'b1, ld_f3[i], ld_a[i], 32'h80FF_7F01, 32'h0,
                  5'(10 + i), 5'(10 + i), 5'd0);
            #1;
            check_val($sformatf("ld_ext%0d", i), wb_data, ld_exp[i]);
            #(-0);
            run_cycle();
        end

        // x0 protection: no write, still retires
        drive(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 32'h0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0);
        #1;
        check_val("x0_we", {31'b0, wb_we}, 32'h0);
        check_val("x0_rd", rs1_data, 32'h0);
        run_cycle();

        // Misaligned LW into x3: suppressed, sticky error, no count
        drive(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 32'h0, 32'hA5A5_0003, 5'd3, 5'd3, 5'd0);
        run_cycle();
        drive(1'b1, 1'b1, 1'b1, 3'd2, 2'd2, 32'hCAFE_F00D, 32'h0, 5'd3, 5'd3, 5'd3);
        #1;
        check_val("mis_we", {31'b0, wb_we}, 32'h0);
        run_cycle();
        check_val("mis_err", {31'b0, misalign_err}, 32'h1);
        for (int i = 0; i < 10; i++) begin
            // Bubbles with write intent: nothing may change
            drive(1'b0, 1'b1, 1'b0, 3'd0, 2'd0, 32'h0, 32'hFFFF_0000, 5'd3, 5'd3, 5'd7);
            run_cycle();
        end
        check_val("mis_err_hold", {31'b0, misalign_err}, 32'h1);
        check_val("x3_kept", rs1_data, 32'hA5A5_0003);

        // Write x5, then async reset mid-cycle
        drive(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 32'h0, 32'hDEAD_BEEF, 5'd5, 5'd5, 5'd0);
        run_cycle();
        drive(1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd5);
        #2;
        check_val("x5_pre_rst", rs1_data, 32'hDEAD_BEEF);
        reset = 1'b1;
        #1;
        check_val("rst_x5", rs1_data, 32'h0);
        check_val("rst_instret_async", instret, 32'h0);
        check_val("rst_err_async", {31'b0, misalign_err}, 32'h0);
        model_reset();
        // A write presented while reset holds across an edge is lost
        drive(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 32'h0, 32'h1111_2222, 5'd6, 5'd0, 5'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 32'h0, 32'h0, 5'd0, 5'd6, 5'd5);
        run_cycle();
        check_val("x6_lost", rs1_data, 32'h0);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic [2:0] f3;
            logic [4:0] d;
            logic [4:0] s1;
            logic [4:0] s2;
            case ($urandom_range(0, 4))
                0:       f3 = 3'd0;
                1:       f3 = 3'd1;
                2:       f3 = 3'd2;
                3:       f3 = 3'd4;
                default: f3 = 3'd5;
            endcase
            d  = 5'($urandom_range(0, 31));
            s1 = ($urandom_range(0, 3) == 0) ? d : 5'($urandom_range(0, 31));
            s2 = ($urandom_range(0, 3) == 0) ? d : 5'($urandom_range(0, 31));
            drive(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)), f3, 2'($urandom_range(0, 3)),
                  $urandom, $urandom, d, s1, s2);
            run_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
